butterfly_pipe: RTL and testbench



---
 rtl/ntt_pkg.sv | 28 ++
 rtl/mod_mul_pipe.sv | 66 ++++++
 rtl/butterfly_pipe.sv | 132 +++++++++++++
 tb/tb_butterfly_pipe.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants and helpers for the Kyber and Dilithium NTT datapaths.
// The constant functions fold Barrett and halving constants in at elaboration time.
package ntt_pkg;

    localparam int KYBER_Q     = 3329;
    localparam int KYBER_W     = 12;
    localparam int DILITHIUM_Q = 8380417;
    localparam int DILITHIUM_W = 23;

    typedef enum logic {
        FWD = 1'b0,
        INV = 1'b1
    } mode_e;

    function automatic int barrett_shift(input int w);
        return 2 * w;
    endfunction

    // floor(2^(2W)/Q); the 64-bit intermediate limits W to 31.
    function automatic logic [63:0] barrett_m(input int w, input int q);
        return (64'd1 << barrett_shift(w)) / 64'(q);
    endfunction

    function automatic int half_q(input int q);
        return (q + 1) / 2;
    endfunction

endpackage

// File: rtl/mod_mul_pipe.sv
// Two-stage modular multiplier: registered full product, then Barrett reduction.
// A single advance enable stalls both stages together.
module mod_mul_pipe
    import ntt_pkg::*;
#(
    parameter int W = 12,
    parameter int Q = 3329
) (
    input  logic         clk,
    input  logic         r,
    input  logic         en,
    input  logic         vld_in,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         vld_out,
    output logic [W-1:0] z
);

    localparam int           SH = barrett_shift(W);
    localparam logic [2*W:0] M  = (2*W+1)'(barrett_m(W, Q));
    localparam logic [W:0]   QX = (W+1)'(Q);

    // Quotient estimate is at most one low, so the remainder lies in [0, 2Q)
    // and fits in W+1 bits; only the low W+1 bits of p - q*Q are needed.
    function automatic logic [W-1:0] barrett_reduce(input logic [2*W-1:0] p);
        logic [W:0] q_est;
        logic [W:0] rem;
        q_est = (W+1)'(({{(2*W+1){1'b0}}, p} * {{(2*W){1'b0}}, M}) >> SH);
        rem   = p[W:0] - q_est * QX;
        return (rem >= QX) ? W'(rem - QX) : W'(rem);
    endfunction

    logic           vld_p2;
    logic [2*W-1:0] prod_p2;

    // S2: full product
    always_ff @(posedge clk) begin
        if (r) begin
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p2 <= vld_in;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            prod_p2 <= {{W{1'b0}}, x} * {{W{1'b0}}, y};
        end
    end

    // S3: reduced product
    always_ff @(posedge clk) begin
        if (r) begin
            vld_out <= 1'b0;
        end else if (en) begin
            vld_out <= vld_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            z <= barrett_reduce(prod_p2);
        end
    end

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage CT/GS butterfly for NTT and inverse NTT with per-beat mode tags.
// One advance enable stalls the whole pipe when the output is held.
module butterfly_pipe
    import ntt_pkg::*;
#(
    parameter int W = 12,
    parameter int Q = 3329
) (
    input  logic         clk,
    input  logic         r,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [W-1:0] in_w,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_inv,
    output logic [W-1:0] out_u,
    output logic [W-1:0] out_v
);

    localparam logic [W:0]   QX     = (W+1)'(Q);
    localparam logic [W-1:0] QW     = W'(Q);
    localparam logic [W-1:0] HALF_Q = W'(half_q(Q));

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return (s >= QX) ? W'(s - QX) : W'(s);
    endfunction

    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [W+1:0] d;
        d = $signed({2'b00, x}) - $signed({2'b00, y});
        return (d < 0) ? W'(d + $signed({1'b0, QX})) : W'(d);
    endfunction

    // Multiply by 2^-1: odd inputs borrow (Q+1)/2, which keeps the result below Q.
    function automatic logic [W-1:0] mod_half(input logic [W-1:0] x);
        return x[0] ? (x >> 1) + HALF_Q : (x >> 1);
    endfunction

    logic         en;
    mode_e        in_mode;
    logic         vld_p1;
    logic         vld_p3;
    mode_e        mode_p1, mode_p2, mode_p3;
    logic [W-1:0] mul_x_p1, mul_w_p1;
    logic [W-1:0] carry_p1, carry_p2, carry_p3;
    logic [W-1:0] prod_p3;
    logic [W-1:0] u_nxt, v_nxt;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign in_mode  = mode_e'(in_inv);

    // S1: inverse beats enter the multiplier as (a-b) and carry (a+b)
    always_ff @(posedge clk) begin
        if (r) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mode_p1  <= in_mode;
            mul_w_p1 <= in_w;
            mul_x_p1 <= (in_mode == INV) ? mod_sub(in_a, in_b) : in_b;
            carry_p1 <= (in_mode == INV) ? mod_add(in_a, in_b) : in_a;
        end
    end

    mod_mul_pipe #(
        .W (W),
        .Q (Q)
    ) u_mul (
        .clk     (clk),
        .r       (r),
        .en      (en),
        .vld_in  (vld_p1),
        .x       (mul_x_p1),
        .y       (mul_w_p1),
        .vld_out (vld_p3),
        .z       (prod_p3)
    );

    // S2/S3: side-band tag and carried operand follow the multiplier
    always_ff @(posedge clk) begin
        if (en) begin
            mode_p2  <= mode_p1;
            carry_p2 <= carry_p1;
            mode_p3  <= mode_p2;
            carry_p3 <= carry_p2;
        end
    end

    always_comb begin
        u_nxt = mod_add(carry_p3, prod_p3);
        v_nxt = mod_sub(carry_p3, prod_p3);
        if (mode_p3 == INV) begin
            u_nxt = mod_half(carry_p3);
            v_nxt = mod_half(prod_p3);
        end
    end

    // S4: output register
    always_ff @(posedge clk) begin
        if (r) begin
            out_valid <= 1'b0;
            out_inv   <= 1'b0;
            out_u     <= '0;
            out_v     <= '0;
        end else if (en) begin
            out_valid <= vld_p3;
            out_inv   <= (mode_p3 == INV);
            out_u     <= u_nxt;
            out_v     <= v_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!r && in_valid && in_ready) begin
            assert (in_a < QW && in_b < QW && in_w < QW)
                else $error("butterfly_pipe: operand not below Q");
        end
    end

endmodule

// File: tb/tb_butterfly_pipe.sv
// Bench for butterfly_pipe: Kyber and Dilithium instances driven with directed and
// random beats, scored against a plain modular-arithmetic reference.
module tb_butterfly_pipe;
    import ntt_pkg::*;

    localparam int KW = KYBER_W;
    localparam int KQ = KYBER_Q;
    localparam int DW = DILITHIUM_W;
    localparam int DQ = DILITHIUM_Q;

    typedef struct {
        longint u;
        longint v;
        bit     inv;
    } res_t;

    logic          clk = 1'b0;
    logic          r;
    logic          k_in_valid, k_in_ready, k_in_inv, k_out_valid, k_out_ready, k_out_inv;
    logic [KW-1:0] k_a, k_b, k_w, k_out_u, k_out_v;
    logic          d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_ready, d_out_inv;
    logic [DW-1:0] d_a, d_b, d_w, d_out_u, d_out_v;

    int   n_chk = 0;
    int   n_err = 0;
    res_t kq[$];
    res_t dq[$];
    res_t k_e, d_e, k_sv, d_sv;
    bit   k_st = 1'b0, d_st = 1'b0;
    bit   k_rr = 1'b0, d_rr = 1'b0;

    always #5 clk = ~clk;

    butterfly_pipe #(.W(KW), .Q(KQ)) dut_k (
        .clk(clk), .r(r), .in_valid(k_in_valid), .in_ready(k_in_ready), .in_inv(k_in_inv),
        .in_a(k_a), .in_b(k_b), .in_w(k_w), .out_valid(k_out_valid), .out_ready(k_out_ready),
        .out_inv(k_out_inv), .out_u(k_out_u), .out_v(k_out_v)
    );

    butterfly_pipe #(.W(DW), .Q(DQ)) dut_d (
        .clk(clk), .r(r), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_inv(d_in_inv),
        .in_a(d_a), .in_b(d_b), .in_w(d_w), .out_valid(d_out_valid), .out_ready(d_out_ready),
        .out_inv(d_out_inv), .out_u(d_out_u), .out_v(d_out_v)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference butterfly using the multiplicative inverse of 2 directly.
    function automatic res_t model(input longint q, input bit inv, input longint a,
                                   input longint b, input longint w);
        res_t   res;
        longint h, t;
        h = (q + 1) / 2;
        if (!inv) begin
            t     = (w * b) % q;
            res.u = (a + t) % q;
            res.v = (a - t + q) % q;
        end else begin
            res.u = (((a + b) % q) * h) % q;
            res.v = (((((a - b + q) % q) * w) % q) * h) % q;
        end
        res.inv = inv;
        return res;
    endfunction

    function automatic longint rnd(input longint q);
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return q - 1;
            default: return longint'($urandom_range(0, 32'(q - 1)));
        endcase
    endfunction

    // Kyber scoreboard, hold and in_ready checks, sampled on the falling edge
    always @(negedge clk) begin
        if (k_st) begin
            chk("k_hold_valid", k_out_valid, 1);
            chk("k_hold_u", k_out_u, k_sv.u);
            chk("k_hold_v", k_out_v, k_sv.v);
            chk("k_hold_inv", k_out_inv, k_sv.inv);
        end
        k_st = 1'b0;
        if (r) begin
            kq.delete();
        end else begin
            if (k_out_valid && !k_out_ready) begin
                chk("k_in_ready_stall", k_in_ready, 0);
                k_st = 1'b1;
                k_sv.u = k_out_u; k_sv.v = k_out_v; k_sv.inv = k_out_inv;
            end
            if (k_out_valid && k_out_ready) begin
                if (kq.size() == 0) begin
                    chk("k_spurious_beat", k_out_valid, 0);
                end else begin
                    k_e = kq.pop_front();
                    chk("k_u", k_out_u, k_e.u);
                    chk("k_v", k_out_v, k_e.v);
                    chk("k_inv", k_out_inv, k_e.inv);
                end
            end
            if (k_in_valid && k_in_ready) kq.push_back(model(KQ, k_in_inv, k_a, k_b, k_w));
        end
    end

    // Dilithium scoreboard, hold and in_ready checks
    always @(negedge clk) begin
        if (d_st) begin
            chk("d_hold_valid", d_out_valid, 1);
            chk("d_hold_u", d_out_u, d_sv.u);
            chk("d_hold_v", d_out_v, d_sv.v);
            chk("d_hold_inv", d_out_inv, d_sv.inv);
        end
        d_st = 1'b0;
        if (r) begin
            dq.delete();
        end else begin
            if (d_out_valid && !d_out_ready) begin
                chk("d_in_ready_stall", d_in_ready, 0);
                d_st = 1'b1;
                d_sv.u = d_out_u; d_sv.v = d_out_v; d_sv.inv = d_out_inv;
            end
            if (d_out_valid && d_out_ready) begin
                if (dq.size() == 0) begin
                    chk("d_spurious_beat", d_out_valid, 0);
                end else begin
                    d_e = dq.pop_front();
                    chk("d_u", d_out_u, d_e.u);
                    chk("d_v", d_out_v, d_e.v);
                    chk("d_inv", d_out_inv, d_e.inv);
                end
            end
            if (d_in_valid && d_in_ready) dq.push_back(model(DQ, d_in_inv, d_a, d_b, d_w));
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (k_rr) k_out_ready = 1'($urandom_range(0, 1));
            if (d_rr) d_out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic drive(input bit dil, input bit inv, input longint a, input longint b,
                         input longint w);
        if (dil) begin
            d_in_valid = 1'b1; d_in_inv = inv; d_a = DW'(a); d_b = DW'(b); d_w = DW'(w);
        end else begin
            k_in_valid = 1'b1; k_in_inv = inv; k_a = KW'(a); k_b = KW'(b); k_w = KW'(w);
        end
    endtask

    task automatic send(input bit dil, input bit inv, input longint a, input longint b,
                        input longint w);
        bit acc = 1'b0;
        drive(dil, inv, a, b, w);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            acc = dil ? d_in_ready : k_in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        chk(dil ? "d_send_accept" : "k_send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        k_in_valid = 1'b0;
        d_in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic directed(input string tag, input bit dil, input bit inv, input longint a,
                            input longint b, input longint w, input longint eu, input longint ev);
        int          n;
        logic [63:0] ov;
        drive(dil, inv, a, b, w);
        for (n = 1; n <= 12; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                k_in_valid = 1'b0;
                d_in_valid = 1'b0;
            end
            ov = dil ? d_out_valid : k_out_valid;
            if (ov) break;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_u"}, dil ? 64'(d_out_u) : 64'(k_out_u), eu);
        chk({tag, "_v"}, dil ? 64'(d_out_v) : 64'(k_out_v), ev);
        chk({tag, "_inv"}, dil ? d_out_inv : k_out_inv, inv);
    endtask

    initial begin
        r = 1'b1;
        k_in_valid = 1'b0; k_in_inv = 1'b0; k_a = '0; k_b = '0; k_w = '0; k_out_ready = 1'b0;
        d_in_valid = 1'b0; d_in_inv = 1'b0; d_a = '0; d_b = '0; d_w = '0; d_out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("k_rst_out_valid", k_out_valid, 0);
        chk("k_rst_out_u", k_out_u, 0);
        chk("k_rst_out_v", k_out_v, 0);
        chk("k_rst_out_inv", k_out_inv, 0);
        chk("d_rst_out_valid", d_out_valid, 0);
        chk("d_rst_out_u", d_out_u, 0);
        r = 1'b0;
        @(posedge clk);
        #1;
        chk("k_rst_in_ready", k_in_ready, 1);
        chk("d_rst_in_ready", d_in_ready, 1);
        k_out_ready = 1'b1;
        d_out_ready = 1'b1;

        directed("k_fwd", 0, 0, 1, 2, 17, 35, 3296);
        directed("k_inv", 0, 1, 5, 2, 17, 1668, 1690);
        directed("k_wrap", 0, 0, 3328, 3328, 3328, 0, 3327);
        for (int i = 0; i < 40; i++) send(0, i[0], rnd(KQ), rnd(KQ), rnd(KQ));
        idle(8);

        directed("d_fwd", 1, 0, 0, 1, 8380416, 8380416, 1);
        directed("d_inv", 1, 1, 5, 2, 17, 4190212, 4190234);
        d_rr = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                d_in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(1, 1'($urandom_range(0, 1)), rnd(DQ), rnd(DQ), rnd(DQ));
        end
        d_rr = 1'b0;
        d_out_ready = 1'b1;
        idle(10);
        chk("d_random_drained", dq.size(), 0);

        k_out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(0, 1'($urandom_range(0, 1)), rnd(KQ), rnd(KQ), rnd(KQ));
                k_in_valid = 1'b0;
            end
            begin
                repeat (10) begin
                    @(posedge clk);
                    #1;
                end
                k_rr = 1'b1;
            end
        join
        k_rr = 1'b0;
        k_out_ready = 1'b1;
        idle(10);
        chk("k_backpressure_drained", kq.size(), 0);

        for (int i = 0; i < 3; i++) send(0, 1'(i), rnd(KQ), rnd(KQ), rnd(KQ));
        drive(0, 0, 7, 8, 9);
        r = 1'b1;
        @(posedge clk);
        #1;
        r = 1'b0;
        k_in_valid = 1'b0;
        chk("k_mid_rst_out_valid", k_out_valid, 0);
        idle(10);
        chk("k_mid_rst_flushed", kq.size(), 0);
        directed("k_after_rst", 0, 0, 100, 3, 5, 115, 85);
        idle(6);

        chk("k_final_queue", kq.size(), 0);
        chk("d_final_queue", dq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached with %0d checks done", n_chk);
        $fatal(1, "simulation time limit");
    end

endmodule
